// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: opcodes, control-field
// codes, FSM state encoding and the decoded-field bundle.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RI     = 2'b10;
  localparam logic [1:0] ALUOP_JALR   = 2'b11;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // Instruction class, chooses the path through EXEC/MEM/WB.
  typedef enum logic [2:0] {
    K_ALU     = 3'd0,
    K_LOAD    = 3'd1,
    K_STORE   = 3'd2,
    K_BRANCH  = 3'd3,
    K_ILLEGAL = 3'd4
  } kind_e;

  typedef struct packed {
    logic [1:0] imm_src;
    logic [1:0] result_src;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       is_lui;
    logic       lui_src;
    logic       is_jalr;
    logic [4:0] lsunit;
  } ctrl_fields_t;

endpackage

// File: rtl/ctrl_field_decode.sv
// Combinational opcode -> control-field map, same encodings as the single-cycle decoder.
// Unknown opcodes produce all-zero fields and the K_ILLEGAL class.
module ctrl_field_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  output ctrl_fields_t fields,
  output kind_e        kind
);

  // Field lookup by opcode; defaults first so every path is fully assigned.
  always_comb begin
    fields            = '0;
    fields.imm_src    = IMM_I;
    fields.result_src = RES_ALU;
    fields.alu_op     = ALUOP_ADD;
    kind              = K_ILLEGAL;
    case (opcode)
      OPC_LUI: begin
        kind           = K_ALU;
        fields.alu_src = 1'b1;
        fields.is_lui  = 1'b1;
        fields.lui_src = 1'b1;
      end
      OPC_AUIPC: begin
        kind           = K_ALU;
        fields.alu_src = 1'b1;
        fields.is_lui  = 1'b1;
      end
      OPC_JAL: begin
        kind              = K_ALU;
        fields.imm_src    = IMM_J;
        fields.result_src = RES_PC4;
      end
      OPC_JALR: begin
        kind              = K_ALU;
        fields.result_src = RES_PC4;
        fields.alu_src    = 1'b1;
        fields.alu_op     = ALUOP_JALR;
        fields.is_jalr    = 1'b1;
      end
      OPC_LOAD: begin
        kind              = K_LOAD;
        fields.result_src = RES_MEM;
        fields.alu_src    = 1'b1;
        fields.lsunit     = {1'b1, 1'b0, funct3};
      end
      OPC_STORE: begin
        kind           = K_STORE;
        fields.imm_src = IMM_S;
        fields.alu_src = 1'b1;
        fields.lsunit  = {1'b1, 1'b1, funct3};
      end
      OPC_BRANCH: begin
        kind           = K_BRANCH;
        fields.imm_src = IMM_B;
        fields.alu_op  = ALUOP_BRANCH;
        fields.branch  = 1'b1;
      end
      OPC_OPIMM: begin
        kind           = K_ALU;
        fields.alu_src = 1'b1;
        fields.alu_op  = ALUOP_RI;
      end
      OPC_OP: begin
        kind          = K_ALU;
        fields.alu_op = ALUOP_RI;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// wait handling, MEM timeout (bus_err) and a retired-instruction counter.
// Optional feature: define ILLEGAL_TRAP_EN to route unknown opcodes through a
// one-cycle TRAP state (illegal pulse); otherwise they retire as NOPs.
// Handshake: an instruction is taken on a cycle where instr_valid && instr_ready;
// instr_ready is high only in FETCH, so instr is ignored at all other times.
module multicycle_ctrl_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int IW          = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [IW-1:0]    instr,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             regwrite,
  output logic             memwrite,
  output logic             memread,
  output logic [1:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             branch,
  output logic             is_lui,
  output logic             lui_src,
  output logic             is_jalr,
  output logic [4:0]       lsunit,
  output logic             busy,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [9:0]       ir_q, ir_d;          // {funct3, opcode} is all the control needs
  ctrl_fields_t     fields_q, fields_d;
  kind_e            kind_q, kind_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  ctrl_fields_t     dec_fields;
  kind_e            dec_kind;

  // Remaining instruction bits belong to the datapath, not to control.
  logic unused_instr;
  assign unused_instr = ^{instr[IW-1:15], instr[11:7]};

  ctrl_field_decode u_dec (
    .opcode (ir_q[6:0]),
    .funct3 (ir_q[9:7]),
    .fields (dec_fields),
    .kind   (dec_kind)
  );

  // State, IR, decoded fields, timeout counter and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      fields_q  <= '0;
      kind_q    <= K_ALU;
      tmo_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      fields_q  <= fields_d;
      kind_q    <= kind_d;
      tmo_q     <= tmo_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and strobe generation; strobes are functions of the registered state.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    fields_d    = fields_q;
    kind_d      = kind_q;
    tmo_d       = tmo_q;
    instret_d   = instret_q;
    instr_ready = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    regwrite    = 1'b0;
    memwrite    = 1'b0;
    memread     = 1'b0;
    bus_err     = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          ir_write = 1'b1;
          ir_d     = {instr[14:12], instr[6:0]};
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        fields_d = dec_fields;
        kind_d   = dec_kind;
        state_d  = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        if (dec_kind == K_ILLEGAL) state_d = S_TRAP;
`endif
      end
      S_EXEC: begin
        case (kind_q)
          K_ALU: state_d = S_WB;
          K_LOAD, K_STORE: begin
            tmo_d   = '0;
            state_d = S_MEM;
          end
          default: begin
            // Branches retire here; unknown opcodes reach this only as NOPs.
            pc_write  = 1'b1;
            instret_d = instret_q + 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        memread  = (kind_q == K_LOAD);
        memwrite = (kind_q == K_STORE);
        if (mem_ready) begin
          if (kind_q == K_LOAD) begin
            state_d = S_WB;
          end else begin
            pc_write  = 1'b1;
            instret_d = instret_q + 1'b1;
            state_d   = S_FETCH;
          end
        end else if (tmo_q == TMO_LAST) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        regwrite  = 1'b1;
        pc_write  = 1'b1;
        instret_d = instret_q + 1'b1;
        state_d   = S_FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    // Decoded fields are only meaningful while an instruction is in flight.
    if (state_d == S_FETCH && state_q != S_FETCH) begin
      fields_d = '0;
      kind_d   = K_ALU;
    end
  end

  assign busy       = (state_q != S_FETCH);
  assign instret    = instret_q;
  assign imm_src    = fields_q.imm_src;
  assign result_src = fields_q.result_src;
  assign alu_src    = fields_q.alu_src;
  assign alu_op     = fields_q.alu_op;
  assign branch     = fields_q.branch;
  assign is_lui     = fields_q.is_lui;
  assign lui_src    = fields_q.lui_src;
  assign is_jalr    = fields_q.is_jalr;
  assign lsunit     = fields_q.lsunit;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm. Each instruction pushes its expected per-cycle
// strobe/field trace onto exp_q; the trace runner pops one entry per cycle.
// Honours ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_ctrl_fsm;

  localparam int W       = 25;
  localparam int MEM_TMO = 15;

  // Strobe words: {instr_ready, ir_write, pc_write, regwrite, memwrite, memread, busy, bus_err, illegal}
  localparam logic [8:0] S_TAKE   = 9'h180;
  localparam logic [8:0] S_IDLE   = 9'h100;
  localparam logic [8:0] S_BUSY   = 9'h004;
  localparam logic [8:0] S_WB     = 9'h064;
  localparam logic [8:0] S_PCW    = 9'h044;
  localparam logic [8:0] S_LDWAIT = 9'h00C;
  localparam logic [8:0] S_STWAIT = 9'h014;
  localparam logic [8:0] S_STDONE = 9'h054;
  localparam logic [8:0] S_STTMO  = 9'h016;
  localparam logic [8:0] S_TRAPC  = 9'h005;

  // Field words: {imm_src, result_src, alu_src, alu_op, branch, is_lui, lui_src, is_jalr, lsunit}
  localparam logic [15:0] F_OP    = 16'h0400;
  localparam logic [15:0] F_OPIMM = 16'h0C00;
  localparam logic [15:0] F_LUI   = 16'h08C0;
  localparam logic [15:0] F_AUIPC = 16'h0880;
  localparam logic [15:0] F_JAL   = 16'hE000;
  localparam logic [15:0] F_JALR  = 16'h2E20;
  localparam logic [15:0] F_LW    = 16'h1812;
  localparam logic [15:0] F_SW    = 16'h481A;
  localparam logic [15:0] F_BEQ   = 16'h8300;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ADDI  = 32'h00108093;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_JALR  = 32'h00008067;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_BAD   = 32'h0000007F;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        mem_ready = 1'b0;
  logic        instr_ready, ir_write, pc_write, regwrite, memwrite, memread;
  logic [1:0]  imm_src, result_src, alu_op;
  logic        alu_src, branch, is_lui, lui_src, is_jalr;
  logic [4:0]  lsunit;
  logic        busy, bus_err, illegal;
  logic [15:0] instret;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.IW(32), .MEM_TIMEOUT(MEM_TMO), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .regwrite(regwrite), .memwrite(memwrite), .memread(memread), .imm_src(imm_src),
    .result_src(result_src), .alu_src(alu_src), .alu_op(alu_op), .branch(branch),
    .is_lui(is_lui), .lui_src(lui_src), .is_jalr(is_jalr), .lsunit(lsunit),
    .busy(busy), .bus_err(bus_err), .illegal(illegal), .instret(instret)
  );

  wire [8:0]   obs_s = {instr_ready, ir_write, pc_write, regwrite, memwrite, memread, busy, bus_err, illegal};
  wire [15:0]  obs_f = {imm_src, result_src, alu_src, alu_op, branch, is_lui, lui_src, is_jalr, lsunit};
  wire [W-1:0] obs   = {obs_s, obs_f};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_instret = '0;
  int           n_vec = 0;
  int           n_bad = 0;

`ifdef ILLEGAL_TRAP_EN
  localparam bit ILL_RETIRES = 1'b0;
`else
  localparam bit ILL_RETIRES = 1'b1;
`endif

  task automatic push(input logic [8:0] s, input logic [15:0] f);
    exp_q.push_back({s, f});
  endtask

  task automatic push_alu(input logic [15:0] f);
    push(S_TAKE, '0); push(S_BUSY, '0); push(S_BUSY, f); push(S_WB, f);
  endtask

  task automatic push_branch(input logic [15:0] f);
    push(S_TAKE, '0); push(S_BUSY, '0); push(S_PCW, f);
  endtask

  task automatic push_load(input logic [15:0] f, input int w);
    push(S_TAKE, '0); push(S_BUSY, '0); push(S_BUSY, f);
    for (int i = 0; i < w; i++) push(S_LDWAIT, f);
    push(S_LDWAIT, f); push(S_WB, f);
  endtask

  task automatic push_store(input logic [15:0] f, input int w);
    push(S_TAKE, '0); push(S_BUSY, '0); push(S_BUSY, f);
    for (int i = 0; i < w; i++) push(S_STWAIT, f);
    push(S_STDONE, f);
  endtask

  task automatic push_illegal;
    push(S_TAKE, '0); push(S_BUSY, '0);
    if (ILL_RETIRES) push(S_PCW, '0);
    else push(S_TRAPC, '0);
  endtask

  // Drives one instruction and checks one trace entry per cycle until exp_q drains.
  // mem_ready is held low from mem_first until mem_at (never, if mem_at < 0), pulsed
  // at mem_at, and random noise elsewhere since it must be ignored outside MEM.
  task automatic run_trace(input string name, input logic [31:0] ins, input bit hold_valid,
                           input int mem_first, input int mem_at);
    int cyc = 0;
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      instr_valid = (cyc == 0) ? 1'b1 : (hold_valid ? 1'b1 : 1'($urandom_range(0, 1)));
      instr       = (cyc == 0) ? ins : $urandom();
      if (mem_at >= 0 && cyc == mem_at) mem_ready = 1'b1;
      else if (cyc >= mem_first && (mem_at < 0 || cyc < mem_at)) mem_ready = 1'b0;
      else mem_ready = 1'($urandom_range(0, 1));
      #1;
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL %s cyc%0d: got strobes=%h fields=%h, want strobes=%h fields=%h",
                 name, cyc, obs_s, obs_f, e[24:16], e[15:0]);
      end
      if (cyc == 0) begin
        n_vec++;
        if (instret !== exp_instret) begin
          n_bad++;
          $display("FAIL %s instret_at_take: got %0d want %0d", name, instret, exp_instret);
        end
      end
      cyc++;
    end
  endtask

  // One idle FETCH cycle: only instr_ready, fields cleared, retire count settled.
  task automatic idle_check(input string name);
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = $urandom();
    mem_ready   = 1'($urandom_range(0, 1));
    #1;
    n_vec++;
    if (obs !== {S_IDLE, 16'h0000}) begin
      n_bad++;
      $display("FAIL %s idle: got strobes=%h fields=%h, want strobes=%h fields=0000",
               name, obs_s, obs_f, S_IDLE);
    end
    n_vec++;
    if (instret !== exp_instret) begin
      n_bad++;
      $display("FAIL %s instret: got %0d want %0d", name, instret, exp_instret);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0;
    #2;
    n_vec++;
    if (obs !== {S_IDLE, 16'h0000} || instret !== 16'd0) begin
      n_bad++;
      $display("FAIL reset: got strobes=%h fields=%h instret=%0d, want strobes=%h fields=0000 instret=0",
               obs_s, obs_f, instret, S_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("reset_release");
  endtask

  task automatic test_alu;
    push_alu(F_OP);    run_trace("add",   I_ADD,   1'b1, 99, -1); exp_instret++; idle_check("add");
    push_alu(F_OPIMM); run_trace("addi",  I_ADDI,  1'b0, 99, -1); exp_instret++; idle_check("addi");
    push_alu(F_LUI);   run_trace("lui",   I_LUI,   1'b0, 99, -1); exp_instret++; idle_check("lui");
    push_alu(F_AUIPC); run_trace("auipc", I_AUIPC, 1'b1, 99, -1); exp_instret++; idle_check("auipc");
    push_alu(F_JAL);   run_trace("jal",   I_JAL,   1'b0, 99, -1); exp_instret++; idle_check("jal");
    push_alu(F_JALR);  run_trace("jalr",  I_JALR,  1'b0, 99, -1); exp_instret++; idle_check("jalr");
  endtask

  task automatic test_load;
    push_load(F_LW, 3); run_trace("lw_wait3", I_LW, 1'b1, 3, 6); exp_instret++; idle_check("lw_wait3");
    push_load(F_LW, 0); run_trace("lw_wait0", I_LW, 1'b0, 3, 3); exp_instret++; idle_check("lw_wait0");
  endtask

  task automatic test_store;
    push_store(F_SW, 0); run_trace("sw_wait0", I_SW, 1'b0, 3, 3); exp_instret++; idle_check("sw_wait0");
    push_store(F_SW, 2); run_trace("sw_wait2", I_SW, 1'b1, 3, 5); exp_instret++; idle_check("sw_wait2");
  endtask

  task automatic test_timeout;
    push(S_TAKE, '0); push(S_BUSY, '0); push(S_BUSY, F_SW);
    for (int i = 0; i < MEM_TMO - 1; i++) push(S_STWAIT, F_SW);
    push(S_STTMO, F_SW);
    run_trace("sw_timeout", I_SW, 1'b0, 3, -1);
    idle_check("sw_timeout");
  endtask

  task automatic test_branch;
    push_branch(F_BEQ); run_trace("beq", I_BEQ, 1'b1, 99, -1); exp_instret++; idle_check("beq");
  endtask

  task automatic test_illegal;
    push_illegal(); run_trace("illegal", I_BAD, 1'b0, 99, -1);
    if (ILL_RETIRES) exp_instret++;
    idle_check("illegal");
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 24; n++) begin
      int k = $urandom_range(0, 9);
      int w = $urandom_range(0, 4);
      case (k)
        0: begin push_alu(F_OP);    run_trace("b2b_add",   I_ADD,   1'b0, 99, -1); end
        1: begin push_alu(F_OPIMM); run_trace("b2b_addi",  I_ADDI,  1'b0, 99, -1); end
        2: begin push_alu(F_LUI);   run_trace("b2b_lui",   I_LUI,   1'b0, 99, -1); end
        3: begin push_alu(F_AUIPC); run_trace("b2b_auipc", I_AUIPC, 1'b0, 99, -1); end
        4: begin push_alu(F_JAL);   run_trace("b2b_jal",   I_JAL,   1'b0, 99, -1); end
        5: begin push_alu(F_JALR);  run_trace("b2b_jalr",  I_JALR,  1'b0, 99, -1); end
        6: begin push_branch(F_BEQ); run_trace("b2b_beq",  I_BEQ,   1'b0, 99, -1); end
        7: begin push_load(F_LW, w);  run_trace("b2b_lw",  I_LW,    1'b0, 3, 3 + w); end
        8: begin push_store(F_SW, w); run_trace("b2b_sw",  I_SW,    1'b0, 3, 3 + w); end
        default: begin push_illegal(); run_trace("b2b_illegal", I_BAD, 1'b0, 99, -1); end
      endcase
      if (k != 9 || ILL_RETIRES) exp_instret++;
    end
    idle_check("b2b_end");
  endtask

  task automatic test_reset_mid;
    // LW stalled two cycles in MEM, then reset lands mid-cycle.
    push(S_TAKE, '0); push(S_BUSY, '0); push(S_BUSY, F_LW); push(S_LDWAIT, F_LW); push(S_LDWAIT, F_LW);
    run_trace("lw_abort", I_LW, 1'b0, 3, -1);
    instr_valid = 1'b0; mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    exp_instret = '0;
    #1;
    n_vec++;
    if (obs !== {S_IDLE, 16'h0000} || instret !== exp_instret) begin
      n_bad++;
      $display("FAIL reset_mid: got strobes=%h fields=%h instret=%0d, want strobes=%h fields=0000 instret=0",
               obs_s, obs_f, instret, S_IDLE);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("reset_mid_release");
    push_alu(F_OP); run_trace("add_after_reset", I_ADD, 1'b1, 99, -1); exp_instret++;
    idle_check("add_after_reset");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
